// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared stage indices, controller state encoding and defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int STG_F     = 0;
    localparam int STG_D     = 1;
    localparam int STG_E     = 2;
    localparam int STG_M     = 3;
    localparam int STG_W_DEF = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN    = 2'd0;
    localparam state_t ST_EXC    = 2'd1;
    localparam state_t ST_DIV_TO = 2'd2;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hbfc00380;
    localparam logic [31:0] ERET_CODE_DEF  = 32'h0000000e;

    function automatic logic [31:0] exc_target(
        input logic [31:0] code,
        input logic [31:0] eret_code,
        input logic [31:0] epc,
        input logic [31:0] vector
    );
        return (code == eret_code) ? epc : vector;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : div_watchdog
// Description : Counts E-stage divider stall cycles; raises DIV_TO on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module div_watchdog #(
    parameter int DIV_TIMEOUT = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic div_start_i,
    input  logic div_ready_i,
    input  logic data_busy_i,
    input  logic exc_accept_i,
    input  logic exc_state_i,
    output logic div_stall_o,
    output logic div_to_o,
    output logic div_timeout_o
);

    localparam int            CW       = $clog2(DIV_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_to_q, div_to_d;
    logic          pulse_q;
    logic          w_hit;

    // While DIV_TO is set, E is released even though the divider never answered.
    assign div_stall_o = div_start_i & ~div_ready_i & ~div_to_q & ~exc_state_i;

    always_comb begin
        w_hit    = div_stall_o & ~data_busy_i & ~exc_accept_i & (cnt_q == CNT_LAST);
        cnt_d    = cnt_q;
        div_to_d = div_to_q;

        if (exc_accept_i || w_hit || !div_stall_o) begin
            cnt_d = '0;
        end else if (!data_busy_i) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (exc_accept_i) begin
            div_to_d = 1'b0;
        end else if (w_hit) begin
            div_to_d = 1'b1;
        end else if (div_to_q && !div_start_i) begin
            div_to_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            div_to_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_to_q <= div_to_d;
            pulse_q  <= w_hit;
        end
    end

    assign div_to_o      = div_to_q;
    assign div_timeout_o = pulse_q & ~rst;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline stall/flush/redirect controller (NSTAGE >= 5).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int          NSTAGE      = 5,
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
    parameter logic [31:0] ERET_CODE   = ERET_CODE_DEF,
    parameter int          DIV_TIMEOUT = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard_stall_d,
    input  logic              inst_busy,
    input  logic              data_busy,
    input  logic              div_start_e,
    input  logic              div_ready_e,
    input  logic              exc_valid_m,
    input  logic [31:0]       exc_type_m,
    input  logic [31:0]       epc_m,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              pc_redirect,
    output logic [31:0]       new_pc,
    output logic              div_timeout
);

    logic        exc_q, exc_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        w_exc_accept;
    logic        w_div_stall;
    logic        w_div_to;
    state_t      w_state;
    int          k;

    // An exception waits in M for any pending data SRAM access to finish.
    assign w_exc_accept = exc_valid_m & ~data_busy & ~exc_q;
    assign w_state      = exc_q ? ST_EXC : (w_div_to ? ST_DIV_TO : ST_RUN);

    div_watchdog #(
        .DIV_TIMEOUT (DIV_TIMEOUT)
    ) u_div_watchdog (
        .clk           (clk),
        .rst           (rst),
        .div_start_i   (div_start_e),
        .div_ready_i   (div_ready_e),
        .data_busy_i   (data_busy),
        .exc_accept_i  (w_exc_accept),
        .exc_state_i   (exc_q),
        .div_stall_o   (w_div_stall),
        .div_to_o      (w_div_to),
        .div_timeout_o (div_timeout)
    );

    always_comb begin
        stall       = '0;
        flush       = '0;
        pc_redirect = 1'b0;
        k           = -1;

        if (rst) begin
            flush = '1;
        end else if (w_state == ST_EXC) begin
            pc_redirect         = 1'b1;
            flush[STG_D:STG_F]  = '1;
        end else if (w_exc_accept) begin
            flush[STG_M:STG_F]  = '1;
        end else begin
            // Deepest requesting stage wins; everything younger holds with it.
            if (inst_busy)      k = STG_F;
            if (hazard_stall_d) k = STG_D;
            if (w_div_stall)    k = STG_E;
            if (data_busy)      k = NSTAGE - 1;
            for (int i = 0; i < NSTAGE; i++) begin
                stall[i] = (i <= k);
                flush[i] = (k >= 0) && (i == k + 1);
            end
        end
    end

    always_comb begin
        exc_d    = w_exc_accept;
        new_pc_d = new_pc_q;
        if (w_exc_accept) begin
            new_pc_d = exc_target(exc_type_m, ERET_CODE, epc_m, EXC_VECTOR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_q    <= 1'b0;
            new_pc_q <= '0;
        end else begin
            exc_q    <= exc_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign new_pc = new_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Scoreboard bench for pipe_ctrl: directed scenarios + random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int          N           = 5;
    localparam int          DIV_TIMEOUT = 40;
    localparam logic [31:0] EXC_VECTOR  = 32'hbfc00380;
    localparam logic [31:0] ERET_CODE   = 32'h0000000e;

    logic          clk = 1'b0;
    logic          rst, hazard_stall_d, inst_busy, data_busy;
    logic          div_start_e, div_ready_e, exc_valid_m;
    logic [31:0]   exc_type_m, epc_m;
    logic [N-1:0]  stall, flush;
    logic          pc_redirect, div_timeout;
    logic [31:0]   new_pc;

    pipe_ctrl #(
        .NSTAGE      (N),
        .EXC_VECTOR  (EXC_VECTOR),
        .ERET_CODE   (ERET_CODE),
        .DIV_TIMEOUT (DIV_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hazard_stall_d (hazard_stall_d),
        .inst_busy      (inst_busy),
        .data_busy      (data_busy),
        .div_start_e    (div_start_e),
        .div_ready_e    (div_ready_e),
        .exc_valid_m    (exc_valid_m),
        .exc_type_m     (exc_type_m),
        .epc_m          (epc_m),
        .stall          (stall),
        .flush          (flush),
        .pc_redirect    (pc_redirect),
        .new_pc         (new_pc),
        .div_timeout    (div_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] stall;
        logic [N-1:0] flush;
        logic         redir;
        logic         tmo;
        logic         pc_chk;
        logic [31:0]  pc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: "redirect owed next cycle", "divider given up on",
    // cycles spent waiting on the divider, pending timeout pulse, target PC.
    bit          m_redirect_next = 1'b0;
    bit          m_div_to        = 1'b0;
    int          m_waited        = 0;
    bit          m_tmo_next      = 1'b0;
    logic [31:0] m_pc            = '0;

    task automatic cyc(input bit r, hz, ib, db, ds, dr, ev,
                       input logic [31:0] et, epc);
        exp_t e;
        int   deepest;
        bit   accept, dstall, tmo_now;
        @(posedge clk);
        #1;
        rst = r; hazard_stall_d = hz; inst_busy = ib; data_busy = db;
        div_start_e = ds; div_ready_e = dr; exc_valid_m = ev;
        exc_type_m = et; epc_m = epc;

        accept = !m_redirect_next && ev && !db;
        dstall = ds && !dr && !m_div_to;
        e = '0;
        e.pc_chk = !r;
        e.pc     = m_pc;
        e.tmo    = !r && m_tmo_next;
        if (r) begin
            e.flush = '1;
        end else if (m_redirect_next) begin
            e.redir = 1'b1;
            e.flush = N'(3);
        end else if (accept) begin
            e.flush = N'(15);
        end else begin
            deepest = -1;
            if (ib)                    deepest = 0;
            if (hz && deepest < 1)     deepest = 1;
            if (dstall && deepest < 2) deepest = 2;
            if (db)                    deepest = N - 1;
            e.stall = N'((1 << (deepest + 1)) - 1);
            if (deepest >= 0 && deepest < N - 1) e.flush = N'(1 << (deepest + 1));
        end
        sb.push_back(e);

        tmo_now = !r && !m_redirect_next && !accept && dstall && !db
                  && (m_waited == DIV_TIMEOUT - 1);
        if (r) begin
            m_redirect_next = 1'b0; m_div_to = 1'b0; m_waited = 0; m_pc = '0;
        end else if (m_redirect_next) begin
            m_redirect_next = 1'b0; m_waited = 0;
        end else if (accept) begin
            m_redirect_next = 1'b1;
            m_pc     = (et == ERET_CODE) ? epc : EXC_VECTOR;
            m_waited = 0;
            m_div_to = 1'b0;
        end else if (tmo_now) begin
            m_div_to = 1'b1; m_waited = 0;
        end else begin
            if (m_div_to && !ds) m_div_to = 1'b0;
            m_waited = !dstall ? 0 : (db ? m_waited : m_waited + 1);
        end
        m_tmo_next = tmo_now;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (stall !== e.stall || flush !== e.flush || pc_redirect !== e.redir ||
                    div_timeout !== e.tmo || (e.pc_chk && new_pc !== e.pc)) begin
                    n_bad++;
                    $display("FAIL outputs@%0t: stall %b/%b flush %b/%b redir %b/%b tmo %b/%b pc %h/%h (actual/required)",
                             $time, stall, e.stall, flush, e.flush, pc_redirect, e.redir,
                             div_timeout, e.tmo, new_pc, e.pc);
                end
            end
        end
    end

    initial begin : stimulus
        bit r_ds = 1'b0, r_db = 1'b0, r_ev = 1'b0;
        bit r_rst, r_dr, r_hz, r_ib;
        logic [31:0] r_et, r_epc;
        int sel;
        rst = 1'b1; hazard_stall_d = 0; inst_busy = 0; data_busy = 0;
        div_start_e = 0; div_ready_e = 0; exc_valid_m = 0; exc_type_m = '0; epc_m = '0;

        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // hazard alone, then hazard with I-SRAM wait
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // D-SRAM wait over a divide, then divider watchdog expiry
        repeat (3) cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        repeat (41) cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ordinary exception
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h4, 32'h1234);
        cyc(0, 1, 1, 1, 1, 0, 1, 32'h4, 32'h1234);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ERET deferred behind data_busy
        repeat (3) cyc(0, 0, 0, 1, 0, 0, 1, 32'he, 32'hbfc00100);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'he, 32'hbfc00100);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-division, then a fresh full count
        repeat (20) cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (42) cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 47) == 0) r_ds = !r_ds;
            if (r_db) r_db = ($urandom_range(0, 2) != 0);
            else      r_db = ($urandom_range(0, 11) == 0);
            r_ev  = ($urandom_range(0, 19) == 0) || (r_ev && r_db);
            r_rst = ($urandom_range(0, 299) == 0);
            r_dr  = ($urandom_range(0, 63) == 0);
            r_hz  = ($urandom_range(0, 5) == 0);
            r_ib  = ($urandom_range(0, 5) == 0);
            sel   = int'($urandom_range(0, 3));
            r_et  = (sel == 0) ? ERET_CODE : (sel == 1) ? 32'h4 : $urandom;
            r_epc = $urandom;
            cyc(r_rst, r_hz, r_ib, r_db, r_ds, r_dr, r_ev, r_et, r_epc);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline stall/flush/redirect controller for the MIPS core.
- Sits beside the combinational hazard/forwarding unit. It consumes that unit's decode-stage stall request, plus SRAM busy lines, the divider handshake and M-stage exception info.
- Produces per-stage stall and flush vectors and a registered PC redirect.
- Adds beyond the previous stall logic: SRAM wait stalls, a divider watchdog, and a two-cycle exception flush/redirect sequence.

Parameters:
NSTAGE, 5, pipeline depth; stage index 0=F, 1=D, 2=E, 3=M, NSTAGE-1=W
EXC_VECTOR, 32'hbfc00380, general exception entry PC
ERET_CODE, 32'h0000000e, exc_type_m value meaning ERET (redirect to EPC)
DIV_TIMEOUT, 40, max cycles E may stall waiting for div_ready_e (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
hazard_stall_d  in  1  load-use/branch/jr stall request from hazard unit
inst_busy  in  1  instruction SRAM access pending
data_busy  in  1  data SRAM access pending (M stage)
div_start_e  in  1  divide instruction in E
div_ready_e  in  1  divider result valid
exc_valid_m  in  1  exception/ERET present in M
exc_type_m  in  32  exception code
epc_m  in  32  EPC value
stall  out  NSTAGE  per-stage hold
flush  out  NSTAGE  per-stage bubble insert
pc_redirect  out  1  load new_pc into PC
new_pc  out  32  redirect target
div_timeout  out  1  one-cycle pulse: divider watchdog expired

Behaviour:
- Reset (rst high on a clk edge): state=RUN, counter=0, new_pc=0.
  - Outputs while rst is high: stall=0, flush=all ones, pc_redirect=0, div_timeout=0.
  - Reset mid-operation aborts any sequence or count.
- States: RUN, EXC, DIV_TO. stall, flush and pc_redirect are combinational from state and inputs.
- EXC state (the one cycle after an exception is accepted):
  - pc_redirect=1; new_pc holds the registered target; flush[1:0]=1; stall=0.
  - All other inputs are ignored.
  - Next state is RUN.
- Exception accept: exc_valid_m & ~data_busy while not in EXC.
  - Same cycle: flush[3:0]=1, stall=0.
  - Registered into new_pc: epc_m if exc_type_m==ERET_CODE, otherwise EXC_VECTOR (every other code, including unknown codes).
  - Next state is EXC; counter is cleared.
  - If exc_valid_m arrives while data_busy is high, the exception is deferred until the cycle data_busy drops. M is stalled meanwhile, so exc_valid_m persists.
- Otherwise, compute the deepest stalled stage k from the active sources:
  - data_busy → k=NSTAGE-1
  - div_stall → k=2
  - hazard_stall_d → k=1
  - inst_busy → k=0
  - Result: stall[k:0]=1 and flush[k+1]=1 when k<NSTAGE-1. With no source active, stall=0 and flush=0.
- div_stall = div_start_e & ~div_ready_e & (state!=DIV_TO).
- Watchdog counter, width $clog2(DIV_TIMEOUT+1):
  - Increments each cycle div_stall is high and data_busy is low; clears when div_stall is low.
  - The cycle div_stall is high with counter==DIV_TIMEOUT-1: div_timeout=1 next cycle, state becomes DIV_TO, counter clears.
  - DIV_TO releases E, treating the result as garbage. It returns to RUN when div_start_e falls or an exception is accepted.
- div_ready_e in the same cycle as div_start_e: no stall.
- data_busy is deliberately not cleared by exceptions: exceptions wait for it.

Decomposition:
- Shared package pipe_pkg: stage index localparams (STG_F..STG_W), state enum encoding, EXC_VECTOR/ERET_CODE defaults. The hazard unit reuses the stage indices.
- Natural sub-module: div_watchdog (counter, timeout pulse, DIV_TO flag). The rest stays flat.

Test Plan:
1. hazard_stall_d=1 only → stall=5'b00011, flush=5'b00100. Add inst_busy=1 → unchanged.
2. data_busy=1 together with div_start_e=1, div_ready_e=0 → stall=5'b11111, flush=0, counter frozen.
3. div_start_e=1 and div_ready_e=0 held for 40 cycles → stall=5'b00111, flush=5'b01000 for cycles 0..39. div_timeout pulses in cycle 40 with stall=0. Drop div_start_e → state RUN.
4. exc_valid_m=1, exc_type_m=32'h4 → same cycle flush=5'b01111. Next cycle pc_redirect=1, new_pc=32'hbfc00380, flush=5'b00011.
5. exc_valid_m=1, exc_type_m=32'he, epc_m=32'hbfc00100, data_busy=1 for 3 cycles → stall=5'b11111 for 3 cycles, no flush. Then flush=5'b01111, then new_pc=32'hbfc00100 with pc_redirect=1.
6. rst asserted mid-division at count 20 → next cycle stall=0, flush=5'b11111. After release, a new divide restarts counting from 0.
